battleship_turn_ctrl: RTL and testbench

Turn sequencer for the two-player battleship datapath. Assembles decoded keyboard events into a letter/number/Enter shot command, presents it to the shot-decider board block with a req/ack handshake, and owns `playerTurn`. Tracks per-player hit totals and declares the winner. Sits between the keyboard decoder and the decider; its `letter`, `number` and `playerTurn` outputs drive the decider directly.

---
 rtl/battleship_pkg.sv | 30 +++
 rtl/battleship_turn_ctrl_keys.sv | 80 ++++++++
 rtl/battleship_turn_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_battleship_turn_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship turn sequencer.
package battleship_pkg;

    typedef enum logic [1:0] {
        KEY_LETTER = 2'd0,
        KEY_DIGIT  = 2'd1,
        KEY_ENTER  = 2'd2,
        KEY_OTHER  = 2'd3
    } key_kind_t;

    typedef enum logic [2:0] {
        WAIT_LETTER,
        WAIT_NUMBER,
        WAIT_ENTER,
        FIRE,
        SHOW,
        GAME_OVER
    } turn_state_t;

    localparam logic PLAYER_ONE = 1'b0;
    localparam logic PLAYER_TWO = 1'b1;

    localparam logic [3:0] KEY_VAL_MAX = 4'd9;

    // Letters A..J and digits 0..9 both map onto 0..9; anything above is junk.
    function automatic logic key_in_range(input logic [3:0] val);
        return (val <= KEY_VAL_MAX);
    endfunction

endpackage

// File: rtl/battleship_turn_ctrl_keys.sv
// Key assembler: builds a letter/number/Enter shot command from decoded keys.
// Only listens while enable_i is high; pulses cmd_ready_o combinationally on
// the accepted Enter so the top can raise fire_req on that same edge.
module turn_key_assembler
    import battleship_pkg::*;
(
    input  logic       clock27_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       key_strobe_i,
    input  logic [1:0] key_kind_i,
    input  logic [3:0] key_val_i,
    output logic [3:0] letter_o,
    output logic [3:0] number_o,
    output logic       cmd_ready_o
);

    turn_state_t state_q, state_d;
    logic [3:0]  letter_q, letter_d;
    logic [3:0]  number_q, number_d;
    key_kind_t   kind;
    logic        accept;

    assign kind     = key_kind_t'(key_kind_i);
    assign letter_o = letter_q;
    assign number_o = number_q;

    // Entry-progress register plus the latched column and row.
    always_ff @(posedge clock27_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= WAIT_LETTER;
            letter_q <= '0;
            number_q <= '0;
        end else begin
            state_q  <= state_d;
            letter_q <= letter_d;
            number_q <= number_d;
        end
    end

    // Letter first, then digit, then Enter; a new letter always restarts the row.
    always_comb begin
        state_d     = state_q;
        letter_d    = letter_q;
        number_d    = number_q;
        cmd_ready_o = 1'b0;
        accept      = enable_i & key_strobe_i & key_in_range(key_val_i);
        if (accept) begin
            case (state_q)
                WAIT_LETTER: begin
                    if (kind == KEY_LETTER) begin
                        letter_d = key_val_i;
                        state_d  = WAIT_NUMBER;
                    end
                end
                WAIT_NUMBER: begin
                    if (kind == KEY_LETTER) begin
                        letter_d = key_val_i;
                    end else if (kind == KEY_DIGIT) begin
                        number_d = key_val_i;
                        state_d  = WAIT_ENTER;
                    end
                end
                WAIT_ENTER: begin
                    if (kind == KEY_LETTER) begin
                        letter_d = key_val_i;
                        state_d  = WAIT_NUMBER;
                    end else if (kind == KEY_DIGIT) begin
                        number_d = key_val_i;
                    end else if (kind == KEY_ENTER) begin
                        cmd_ready_o = 1'b1;
                        state_d     = WAIT_LETTER;
                    end
                end
                default: state_d = WAIT_LETTER;
            endcase
        end
    end

endmodule

// File: rtl/battleship_turn_ctrl.sv
// Turn sequencer: fires assembled shots at the decider, shows the result,
// keeps per-player hit totals and hands the turn over or declares a winner.
module battleship_turn_ctrl
    import battleship_pkg::*;
#(
    parameter int SHIP_CELLS    = 17,
    parameter int RESULT_CYCLES = 1024,
    parameter int ACK_TIMEOUT   = 4096
)
(
    input  logic       clock27,
    input  logic       reset,
    input  logic       key_strobe,
    input  logic [1:0] key_kind,
    input  logic [3:0] key_val,
    input  logic       fire_ack,
    input  logic       hit,
    input  logic       repeat_shot,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       playerTurn,
    output logic       fire_req,
    output logic       result_valid,
    output logic       result_hit,
    output logic [4:0] hits_p1,
    output logic [4:0] hits_p2,
    output logic       game_over,
    output logic       winner,
    output logic       new_game,
    output logic       timeout_err
);

    localparam int TW = $clog2(RESULT_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    // In this FSM WAIT_LETTER stands for the whole key-entry phase; the
    // assembler tracks the finer letter/number/enter progress itself.
    turn_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] ackCnt_q, ackCnt_d;
    logic [4:0]    hitsP1_q, hitsP1_d, hitsP2_q, hitsP2_d;
    logic          turn_q, turn_d, fireReq_q, fireReq_d;
    logic          resValid_q, resValid_d, resHit_q, resHit_d;
    logic          rep_q, rep_d, gameOver_q, gameOver_d;
    logic          winner_q, winner_d, newGame_q, newGame_d;
    logic          timeoutErr_q, timeoutErr_d;
    logic          cmdReady, scored;
    logic [4:0]    curHits;

    turn_key_assembler u_keys (
        .clock27_i    (clock27),
        .reset_i      (reset),
        .enable_i     (state_q == WAIT_LETTER),
        .key_strobe_i (key_strobe),
        .key_kind_i   (key_kind),
        .key_val_i    (key_val),
        .letter_o     (letter),
        .number_o     (number),
        .cmd_ready_o  (cmdReady)
    );

    assign playerTurn   = turn_q;
    assign fire_req     = fireReq_q;
    assign result_valid = resValid_q;
    assign result_hit   = resHit_q;
    assign hits_p1      = hitsP1_q;
    assign hits_p2      = hitsP2_q;
    assign game_over    = gameOver_q;
    assign winner       = winner_q;
    assign new_game     = newGame_q;
    assign timeout_err  = timeoutErr_q;

    assign scored  = hit & ~repeat_shot;
    assign curHits = (turn_q == PLAYER_ONE) ? hitsP1_q : hitsP2_q;

    // All sequencer state and every output is registered.
    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_LETTER;
            timer_q      <= '0;
            ackCnt_q     <= '0;
            hitsP1_q     <= '0;
            hitsP2_q     <= '0;
            turn_q       <= PLAYER_ONE;
            fireReq_q    <= 1'b0;
            resValid_q   <= 1'b0;
            resHit_q     <= 1'b0;
            rep_q        <= 1'b0;
            gameOver_q   <= 1'b0;
            winner_q     <= 1'b0;
            newGame_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ackCnt_q     <= ackCnt_d;
            hitsP1_q     <= hitsP1_d;
            hitsP2_q     <= hitsP2_d;
            turn_q       <= turn_d;
            fireReq_q    <= fireReq_d;
            resValid_q   <= resValid_d;
            resHit_q     <= resHit_d;
            rep_q        <= rep_d;
            gameOver_q   <= gameOver_d;
            winner_q     <= winner_d;
            newGame_q    <= newGame_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Fire handshake with timeout, result hold, turn hand-over and game end.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ackCnt_d     = ackCnt_q;
        hitsP1_d     = hitsP1_q;
        hitsP2_d     = hitsP2_q;
        turn_d       = turn_q;
        fireReq_d    = fireReq_q;
        resValid_d   = resValid_q;
        resHit_d     = resHit_q;
        rep_d        = rep_q;
        gameOver_d   = gameOver_q;
        winner_d     = winner_q;
        newGame_d    = 1'b0;
        timeoutErr_d = 1'b0;
        case (state_q)
            WAIT_LETTER: begin
                if (cmdReady) begin
                    state_d   = FIRE;
                    fireReq_d = 1'b1;
                    ackCnt_d  = '0;
                end
            end
            FIRE: begin
                if (fire_ack) begin
                    fireReq_d  = 1'b0;
                    resHit_d   = scored;
                    rep_d      = repeat_shot;
                    if (scored && turn_q == PLAYER_ONE && hitsP1_q < 5'(SHIP_CELLS)) begin
                        hitsP1_d = hitsP1_q + 5'd1;
                    end
                    if (scored && turn_q == PLAYER_TWO && hitsP2_q < 5'(SHIP_CELLS)) begin
                        hitsP2_d = hitsP2_q + 5'd1;
                    end
                    resValid_d = 1'b1;
                    timer_d    = TW'(RESULT_CYCLES - 1);
                    state_d    = SHOW;
                end else if (ackCnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    fireReq_d    = 1'b0;
                    timeoutErr_d = 1'b1;
                    state_d      = WAIT_LETTER;
                end else begin
                    ackCnt_d = ackCnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    resValid_d = 1'b0;
                    if (curHits == 5'(SHIP_CELLS)) begin
                        gameOver_d = 1'b1;
                        winner_d   = turn_q;
                        state_d    = GAME_OVER;
                    end else begin
                        if (!rep_q) begin
                            turn_d = (turn_q == PLAYER_ONE) ? PLAYER_TWO : PLAYER_ONE;
                        end
                        state_d = WAIT_LETTER;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAME_OVER: begin
                if (key_strobe && key_kind_t'(key_kind) == KEY_ENTER && key_in_range(key_val)) begin
                    hitsP1_d   = '0;
                    hitsP2_d   = '0;
                    turn_d     = PLAYER_ONE;
                    gameOver_d = 1'b0;
                    newGame_d  = 1'b1;
                    state_d    = WAIT_LETTER;
                end
            end
            default: state_d = WAIT_LETTER;
        endcase
    end

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Self-checking bench for battleship_turn_ctrl with a cycle-level game model.
module tb_battleship_turn_ctrl;

    localparam int SC = 2;
    localparam int RC = 16;
    localparam int AT = 8;

    localparam logic [1:0] K_LETTER = 2'd0;
    localparam logic [1:0] K_DIGIT  = 2'd1;
    localparam logic [1:0] K_ENTER  = 2'd2;
    localparam logic [1:0] K_OTHER  = 2'd3;

    logic       clock27 = 1'b0;
    logic       reset = 1'b1;
    logic       key_strobe = 1'b0;
    logic [1:0] key_kind = 2'd0;
    logic [3:0] key_val = 4'd0;
    logic       fire_ack = 1'b0;
    logic       hit = 1'b0;
    logic       repeat_shot = 1'b0;
    logic [3:0] letter, number;
    logic       playerTurn, fire_req, result_valid, result_hit;
    logic [4:0] hits_p1, hits_p2;
    logic       game_over, winner, new_game, timeout_err;

    int assertCount = 0;
    int failCount = 0;

    // model state
    int mLetter = 0, mNumber = 0, mHaveL = 0, mHaveN = 0, mTurn = 0;
    int mH1 = 0, mH2 = 0, mFire = 0, mAge = 0, mShowLeft = 0;
    int mResHit = 0, mRep = 0, mOver = 0, mWinner = 0, mNewGame = 0, mTimeout = 0;

    // run-length and pulse monitors
    int fireRun = 0, lastFireLen = 0, validRun = 0, lastValidLen = 0;
    int timeoutPulses = 0, newGamePulses = 0;

    battleship_turn_ctrl #(
        .SHIP_CELLS    (SC),
        .RESULT_CYCLES (RC),
        .ACK_TIMEOUT   (AT)
    ) dut (
        .clock27      (clock27),
        .reset        (reset),
        .key_strobe   (key_strobe),
        .key_kind     (key_kind),
        .key_val      (key_val),
        .fire_ack     (fire_ack),
        .hit          (hit),
        .repeat_shot  (repeat_shot),
        .letter       (letter),
        .number       (number),
        .playerTurn   (playerTurn),
        .fire_req     (fire_req),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .hits_p1      (hits_p1),
        .hits_p2      (hits_p2),
        .game_over    (game_over),
        .winner       (winner),
        .new_game     (new_game),
        .timeout_err  (timeout_err)
    );

    always #5 clock27 = ~clock27;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] kind, input int val);
        @(negedge clock27);
        key_strobe = 1'b1;
        key_kind   = kind;
        key_val    = 4'(val);
        @(negedge clock27);
        key_strobe = 1'b0;
    endtask

    // Wait for fire_req, then raise fire_ack after the given number of cycles.
    task automatic fireAndAck(input int delay, input logic hitV, input logic repV);
        int n = 0;
        while (fire_req !== 1'b1 && n < 50) begin
            @(negedge clock27);
            n++;
        end
        checkOutput("fire_req_seen", int'(fire_req === 1'b1), 1);
        repeat (delay) @(negedge clock27);
        fire_ack    = 1'b1;
        hit         = hitV;
        repeat_shot = repV;
        @(negedge clock27);
        fire_ack    = 1'b0;
        hit         = 1'b0;
        repeat_shot = 1'b0;
    endtask

    // Game model from the rules: progress flags for key entry, countdowns for fire and show.
    always @(posedge clock27 or posedge reset) begin : model
        int lt, nm, hl, hn, tn, h1, h2, fr, age, sl, rh, rp, go, wn, ng, te;
        if (reset) begin
            mLetter <= 0; mNumber <= 0; mHaveL <= 0; mHaveN <= 0; mTurn <= 0;
            mH1 <= 0; mH2 <= 0; mFire <= 0; mAge <= 0; mShowLeft <= 0;
            mResHit <= 0; mRep <= 0; mOver <= 0; mWinner <= 0; mNewGame <= 0; mTimeout <= 0;
        end else begin
            lt = mLetter; nm = mNumber; hl = mHaveL; hn = mHaveN; tn = mTurn;
            h1 = mH1; h2 = mH2; fr = mFire; age = mAge; sl = mShowLeft;
            rh = mResHit; rp = mRep; go = mOver; wn = mWinner;
            ng = 0; te = 0;
            if (go != 0) begin
                if (key_strobe && key_kind == K_ENTER && key_val <= 9) begin
                    h1 = 0; h2 = 0; tn = 0; ng = 1; go = 0;
                end
            end else if (sl > 0) begin
                sl = sl - 1;
                if (sl == 0) begin
                    if (((tn != 0) ? h2 : h1) == SC) begin
                        go = 1; wn = tn;
                    end else if (rp == 0) begin
                        tn = 1 - tn;
                    end
                end
            end else if (fr != 0) begin
                if (fire_ack) begin
                    fr = 0;
                    rh = int'(hit && !repeat_shot);
                    rp = int'(repeat_shot);
                    if (rh != 0) begin
                        if (tn == 0 && h1 < SC) h1 = h1 + 1;
                        else if (tn == 1 && h2 < SC) h2 = h2 + 1;
                    end
                    sl = RC;
                end else begin
                    age = age + 1;
                    if (age == AT) begin
                        fr = 0; te = 1;
                    end
                end
            end else if (key_strobe && key_val <= 9) begin
                if (key_kind == K_LETTER) begin
                    lt = int'(key_val); hl = 1; hn = 0;
                end else if (key_kind == K_DIGIT && hl != 0) begin
                    nm = int'(key_val); hn = 1;
                end else if (key_kind == K_ENTER && hl != 0 && hn != 0) begin
                    fr = 1; age = 0; hl = 0; hn = 0;
                end
            end
            mLetter <= lt; mNumber <= nm; mHaveL <= hl; mHaveN <= hn; mTurn <= tn;
            mH1 <= h1; mH2 <= h2; mFire <= fr; mAge <= age; mShowLeft <= sl;
            mResHit <= rh; mRep <= rp; mOver <= go; mWinner <= wn; mNewGame <= ng; mTimeout <= te;
        end
    end

    // Compare every output against the model once per cycle, away from the clock edge.
    always @(negedge clock27) begin
        checkOutput("letter", int'(letter), mLetter);
        checkOutput("number", int'(number), mNumber);
        checkOutput("playerTurn", int'(playerTurn), mTurn);
        checkOutput("fire_req", int'(fire_req), mFire);
        checkOutput("result_valid", int'(result_valid), int'(mShowLeft > 0));
        checkOutput("result_hit", int'(result_hit), mResHit);
        checkOutput("hits_p1", int'(hits_p1), mH1);
        checkOutput("hits_p2", int'(hits_p2), mH2);
        checkOutput("game_over", int'(game_over), mOver);
        checkOutput("winner", int'(winner), mWinner);
        checkOutput("new_game", int'(new_game), mNewGame);
        checkOutput("timeout_err", int'(timeout_err), mTimeout);
    end

    // Run lengths of fire_req and result_valid, plus pulse counters.
    always @(negedge clock27) begin
        if (fire_req) fireRun <= fireRun + 1;
        else if (fireRun != 0) begin lastFireLen <= fireRun; fireRun <= 0; end
        if (result_valid) validRun <= validRun + 1;
        else if (validRun != 0) begin lastValidLen <= validRun; validRun <= 0; end
        if (timeout_err) timeoutPulses <= timeoutPulses + 1;
        if (new_game) newGamePulses <= newGamePulses + 1;
    end

    initial begin
        repeat (3) @(negedge clock27);
        reset = 1'b0;
        checkOutput("reset_fire_req", int'(fire_req), 0);
        checkOutput("reset_turn", int'(playerTurn), 0);
        checkOutput("reset_hits_p1", int'(hits_p1), 0);

        $display("[TB] basic shot C4 by player one");
        applyStimulus(K_LETTER, 12);
        applyStimulus(K_OTHER, 1);
        applyStimulus(K_LETTER, 2);
        applyStimulus(K_DIGIT, 4);
        applyStimulus(K_ENTER, 0);
        fireAndAck(3, 1'b1, 1'b0);
        repeat (RC + 4) @(negedge clock27);
        checkOutput("basic_letter", int'(letter), 2);
        checkOutput("basic_number", int'(number), 4);
        checkOutput("basic_fire_len", lastFireLen, 4);
        checkOutput("basic_valid_len", lastValidLen, RC);
        checkOutput("basic_hits_p1", int'(hits_p1), 1);
        checkOutput("basic_turn", int'(playerTurn), 1);

        $display("[TB] key editing by player two");
        applyStimulus(K_LETTER, 1);
        applyStimulus(K_ENTER, 0);
        applyStimulus(K_DIGIT, 7);
        applyStimulus(K_LETTER, 0);
        applyStimulus(K_ENTER, 0);
        applyStimulus(K_DIGIT, 3);
        applyStimulus(K_ENTER, 0);
        checkOutput("edit_letter", int'(letter), 0);
        checkOutput("edit_number", int'(number), 3);
        fireAndAck(1, 1'b0, 1'b0);
        repeat (RC + 4) @(negedge clock27);
        checkOutput("edit_hits_p2", int'(hits_p2), 0);
        checkOutput("edit_turn", int'(playerTurn), 0);

        $display("[TB] repeat shot by player one");
        applyStimulus(K_LETTER, 2);
        applyStimulus(K_DIGIT, 4);
        applyStimulus(K_ENTER, 0);
        fireAndAck(2, 1'b1, 1'b1);
        repeat (RC + 4) @(negedge clock27);
        checkOutput("repeat_result_hit", int'(result_hit), 0);
        checkOutput("repeat_hits_p1", int'(hits_p1), 1);
        checkOutput("repeat_turn", int'(playerTurn), 0);

        $display("[TB] ack timeout");
        applyStimulus(K_LETTER, 0);
        applyStimulus(K_DIGIT, 0);
        applyStimulus(K_ENTER, 0);
        repeat (AT + 4) @(negedge clock27);
        checkOutput("timeout_fire_len", lastFireLen, AT);
        checkOutput("timeout_pulses", timeoutPulses, 1);
        checkOutput("timeout_fire_req", int'(fire_req), 0);
        checkOutput("timeout_turn", int'(playerTurn), 0);

        $display("[TB] winning shot J9");
        applyStimulus(K_LETTER, 9);
        applyStimulus(K_DIGIT, 9);
        applyStimulus(K_ENTER, 0);
        fireAndAck(0, 1'b1, 1'b0);
        repeat (RC + 4) @(negedge clock27);
        applyStimulus(K_LETTER, 3);
        checkOutput("win_game_over", int'(game_over), 1);
        checkOutput("win_winner", int'(winner), 0);
        checkOutput("win_hits_p1", int'(hits_p1), 2);
        applyStimulus(K_ENTER, 0);
        repeat (2) @(negedge clock27);
        checkOutput("newgame_pulses", newGamePulses, 1);
        checkOutput("newgame_game_over", int'(game_over), 0);
        checkOutput("newgame_hits_p1", int'(hits_p1), 0);
        checkOutput("newgame_turn", int'(playerTurn), 0);

        $display("[TB] reset during FIRE");
        applyStimulus(K_LETTER, 5);
        applyStimulus(K_DIGIT, 6);
        applyStimulus(K_ENTER, 0);
        @(negedge clock27);
        checkOutput("prereset_fire_req", int'(fire_req), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_fire_req", int'(fire_req), 0);
        checkOutput("async_letter", int'(letter), 0);
        checkOutput("async_hits_p1", int'(hits_p1), 0);
        repeat (2) @(negedge clock27);
        reset = 1'b0;
        applyStimulus(K_LETTER, 2);
        applyStimulus(K_DIGIT, 4);
        applyStimulus(K_ENTER, 0);
        fireAndAck(3, 1'b1, 1'b0);
        repeat (RC + 4) @(negedge clock27);
        checkOutput("post_reset_hits_p1", int'(hits_p1), 1);
        checkOutput("post_reset_turn", int'(playerTurn), 1);

        $display("[TB] stray ack while idle");
        @(negedge clock27);
        fire_ack = 1'b1;
        hit      = 1'b1;
        @(negedge clock27);
        fire_ack = 1'b0;
        hit      = 1'b0;
        repeat (3) @(negedge clock27);
        checkOutput("stray_hits_p2", int'(hits_p2), 0);
        checkOutput("stray_result_valid", int'(result_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
